panel_rx: RTL and testbench

PANEL_RX -- requirements
Module: panel_rx

---
 rtl/panel_rx_pkg.sv | 33 +++
 rtl/panel_rx_sync.sv | 69 ++++++
 rtl/panel_rx.sv | 180 ++++++++++++++++++
 tb/tb_panel_rx.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_rx_pkg.sv
// -----------------------------------------------------------------------------
// panel_rx_pkg
// Shared definitions for the panel serial receiver: receiver FSM state
// encoding, frame geometry defaults and the 3-sample majority helper.
//
// Configuration macro: PANEL_RX_GLITCH_FILTER_EN
//   When defined, GLITCH_FILTER_EN is set and panel_rx_sync instances that
//   request filtering insert a 3-sample majority filter after synchronization.
// -----------------------------------------------------------------------------
package panel_rx_pkg;

  // One frame is four lamp rows.
  localparam int ROW_BITS        = 36;
  localparam int DEF_FRAME_BITS  = 4 * ROW_BITS;
  localparam int DEF_SYNC_STAGES = 2;

`ifdef PANEL_RX_GLITCH_FILTER_EN
  localparam bit GLITCH_FILTER_EN = 1'b1;
`else
  localparam bit GLITCH_FILTER_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,  // waiting for bit 0 of a frame
    ST_SHIFT = 2'd1,  // collecting frame bits
    ST_OVER  = 2'd2   // excess bits seen, discarding until next bit 0
  } state_e;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage : panel_rx_pkg

// File: rtl/panel_rx_sync.sv
// -----------------------------------------------------------------------------
// panel_rx_sync
// Multi-flop synchronizer for one asynchronous panel input, with an optional
// 3-sample majority filter behind it (only built when the package's
// GLITCH_FILTER_EN is set, i.e. PANEL_RX_GLITCH_FILTER_EN is defined, and the
// instance sets FILTER).
//
// Parameters:
//   STAGES - number of synchronizer flops (>= 1)
//   IDLE   - level loaded into every flop on reset (line idle level)
//   FILTER - request the majority filter on this input
// Ports:
//   clk_i  - sampling clock
//   rst_i  - asynchronous active-high reset
//   d_i    - asynchronous input line
//   q_o    - synchronized (optionally filtered) copy of d_i
// -----------------------------------------------------------------------------
module panel_rx_sync
  import panel_rx_pkg::*;
#(
  parameter int   STAGES = DEF_SYNC_STAGES,
  parameter logic IDLE   = 1'b1,
  parameter bit   FILTER = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic              synced;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbour; with = the chain would collapse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{IDLE}};
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign synced = sync_q[STAGES-1];

  generate
    if (FILTER && GLITCH_FILTER_EN) begin : g_filter
      // Three-deep history; a level change must persist two samples before
      // the majority follows it, so a single-sample glitch never passes.
      logic [2:0] hist_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          hist_q <= {3{IDLE}};
        end else begin
          hist_q <= {hist_q[1:0], synced};
        end
      end

      assign q_o = majority3(hist_q);
    end else begin : g_direct
      assign q_o = synced;
    end
  endgenerate

endmodule : panel_rx_sync

// File: rtl/panel_rx.sv
// -----------------------------------------------------------------------------
// panel_rx
// Receiver for the lamp panel serial link driven by the QSIC. Bits are
// sampled on the rising edge of the (inverted-polarity) panel clock, frames
// are delimited by an active-low latch during bit 0, and a completed frame
// is copied to a double-buffered lamp register with a one-cycle strobe.
//
// Configuration macro: PANEL_RX_GLITCH_FILTER_EN (majority filter on ip_clk,
// adds two clk20 cycles of latency to the sample point).
//
// Parameters:
//   FRAME_BITS  - lamp bits per frame (default 144, four 36-bit rows)
//   SYNC_STAGES - synchronizer depth on each serial input
// Ports:
//   clk20     - 20 MHz system clock, all state on its rising edge
//   reset     - asynchronous active-high reset
//   ip_clk    - panel serial clock (inverted, idles high)
//   ip_latch  - frame marker, low during bit 0
//   ip_out    - panel serial data (inverted, low = lamp on)
//   lamps     - displayed lamp states, first-received bit in the MSB
//   frame_stb - one-cycle pulse when lamps updates
//   frame_err - sticky short/overlong frame flag, cleared by a good frame
// -----------------------------------------------------------------------------
module panel_rx
  import panel_rx_pkg::*;
#(
  parameter int FRAME_BITS  = DEF_FRAME_BITS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                  clk20,
  input  logic                  reset,
  input  logic                  ip_clk,
  input  logic                  ip_latch,
  input  logic                  ip_out,
  output logic [FRAME_BITS-1:0] lamps,
  output logic                  frame_stb,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_FULL = cnt_t'(FRAME_BITS);
  localparam cnt_t CNT_OVER = cnt_t'(FRAME_BITS + 1);

  // ---------------------------------------------------------------------------
  // Input synchronizers (all lines idle high)
  // ---------------------------------------------------------------------------
  logic clk_s;
  logic latch_s;
  logic data_s;

  panel_rx_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b1), .FILTER(1'b1)) u_sync_clk (
    .clk_i (clk20),
    .rst_i (reset),
    .d_i   (ip_clk),
    .q_o   (clk_s)
  );

  panel_rx_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b1), .FILTER(1'b0)) u_sync_latch (
    .clk_i (clk20),
    .rst_i (reset),
    .d_i   (ip_latch),
    .q_o   (latch_s)
  );

  panel_rx_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b1), .FILTER(1'b0)) u_sync_data (
    .clk_i (clk20),
    .rst_i (reset),
    .d_i   (ip_out),
    .q_o   (data_s)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  cnt_t                  cnt_q,   cnt_d;
  logic                  pend_q,  pend_d;   // frame complete, transfer next cycle
  logic [FRAME_BITS-1:0] lamps_q, lamps_d;
  logic                  stb_q,   stb_d;
  logic                  err_q,   err_d;
  logic                  clk_prev_q;

  logic sample;
  logic bit0;
  logic rx_bit;
  cnt_t cnt_inc;

  // Rising edge of the synchronized panel clock is mid-bit: the QSIC moves
  // data on the falling edge.
  assign sample  = clk_s & ~clk_prev_q;
  assign bit0    = sample & ~latch_s;
  assign rx_bit  = ~data_s;
  assign cnt_inc = cnt_q + CNT_ONE;

  // NOTE: the wide shift register is reset along with everything else so no
  // stale bits from before reset can ever be transferred to the lamps.
  always_ff @(posedge clk20 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_HUNT;
      shift_q    <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      lamps_q    <= '0;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      lamps_q    <= lamps_d;
      stb_q      <= stb_d;
      err_q      <= err_d;
      clk_prev_q <= clk_s;
    end
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    pend_d  = 1'b0;
    lamps_d = lamps_q;
    stb_d   = 1'b0;
    err_d   = err_q;

    // Transfer of a completed frame is evaluated first so a bit 0 landing in
    // the same cycle restarts only after the old frame has been captured.
    if (pend_q) begin
      lamps_d = shift_q;
      stb_d   = 1'b1;
      err_d   = 1'b0;
    end

    if (bit0) begin
      // Bit 0 always restarts, whatever state we are in; it is only an error
      // when it cuts a partially received frame short.
      if (state_q == ST_SHIFT && cnt_q > CNT_ONE && cnt_q < CNT_FULL) begin
        err_d = 1'b1;
      end
      shift_d    = '0;
      shift_d[0] = rx_bit;
      cnt_d      = CNT_ONE;
      state_d    = ST_SHIFT;
    end else if (sample) begin
      unique case (state_q)
        ST_SHIFT: begin
          if (cnt_q == CNT_FULL) begin
            // One bit too many: the good copy is already in lamps.
            cnt_d   = CNT_OVER;
            state_d = ST_OVER;
            err_d   = 1'b1;
          end else begin
            shift_d = {shift_q[FRAME_BITS-2:0], rx_bit};
            cnt_d   = cnt_inc;
            pend_d  = (cnt_inc == CNT_FULL);
          end
        end
        ST_OVER: begin
          cnt_d = CNT_OVER;
        end
        default: begin
          // ST_HUNT: data before the first bit 0 is meaningless.
        end
      endcase
    end
  end

  assign lamps     = lamps_q;
  assign frame_stb = stb_q;
  assign frame_err = err_q;

endmodule : panel_rx

// File: tb/tb_panel_rx.sv
// -----------------------------------------------------------------------------
// tb_panel_rx
// Self-checking bench for panel_rx. A bit-level serial driver feeds random and
// patterned frames; a frame-level reference model (queue of bits since the
// last latch) predicts lamps, frame_err and the number of frame_stb pulses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_panel_rx;

  localparam int FB   = 144;
  localparam int HALF = 10;   // clk20 cycles per half serial bit

  typedef bit bitq_t[$];

  logic          clk20 = 1'b0;
  logic          reset;
  logic          ip_clk;
  logic          ip_latch;
  logic          ip_out;
  logic [FB-1:0] lamps;
  logic          frame_stb;
  logic          frame_err;

  int compared   = 0;
  int mismatched = 0;

  // DUT strobe monitor
  int   dut_stb  = 0;
  logic stb_prev = 1'b0;

  // Reference model
  logic [FB-1:0] m_lamps;
  logic          m_err;
  int            m_cnt;     // bits since last latch, 0 = hunting
  int            m_stb;
  bit            m_bits[$];

  always #25 clk20 = ~clk20;

  panel_rx #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
    .clk20     (clk20),
    .reset     (reset),
    .ip_clk    (ip_clk),
    .ip_latch  (ip_latch),
    .ip_out    (ip_out),
    .lamps     (lamps),
    .frame_stb (frame_stb),
    .frame_err (frame_err)
  );

  always @(negedge clk20) begin
    if (frame_stb) begin
      dut_stb++;
      compared++;
      if (stb_prev) begin
        mismatched++;
        $display("FAIL stb_width: frame_stb high for 2+ cycles, required 1 cycle");
      end
    end
    stb_prev = frame_stb;
  end

  // ---------------------------------------------------------------------------
  // Model and driver
  // ---------------------------------------------------------------------------
  task automatic model_reset();
    m_lamps = '0;
    m_err   = 1'b0;
    m_cnt   = 0;
    m_bits.delete();
  endtask

  task automatic model_bit(input bit b, input bit latch);
    if (latch) begin
      if (m_cnt > 1 && m_cnt < FB) m_err = 1'b1;
      m_bits.delete();
      m_bits.push_back(b);
      m_cnt = 1;
    end else if (m_cnt > 0) begin
      m_cnt++;
      if (m_cnt <= FB) m_bits.push_back(b);
      if (m_cnt == FB) begin
        for (int i = 0; i < FB; i++) m_lamps[FB-1-i] = m_bits[i];
        m_stb++;
        m_err = 1'b0;
      end
      if (m_cnt == FB + 1) m_err = 1'b1;
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk20);
  endtask

  // One serial bit: falling edge moves data, rising edge is the sample point.
  task automatic send_bit(input bit b, input bit latch, input bit glitch);
    @(negedge clk20);
    ip_clk   = 1'b0;
    ip_out   = ~b;
    ip_latch = ~latch;
    wait_clks(HALF);
    ip_clk = 1'b1;
    model_bit(b, latch);
    if (glitch) begin
      wait_clks(4);
      ip_clk = 1'b0;
      wait_clks(1);
      ip_clk = 1'b1;
      wait_clks(HALF - 5);
    end else begin
      wait_clks(HALF);
    end
  endtask

  task automatic send_bits(input bitq_t bits, input bit latch_first, input int glitch_at);
    foreach (bits[i]) send_bit(bits[i], latch_first && (i == 0), i == glitch_at);
  endtask

  function automatic logic [FB-1:0] rand_word();
    logic [FB-1:0] w;
    for (int i = 0; i < FB; i++) w[i] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  function automatic bitq_t word_bits(input logic [FB-1:0] w);
    bitq_t q;
    for (int i = FB - 1; i >= 0; i--) q.push_back(w[i]);
    return q;
  endfunction

  function automatic bitq_t rand_bits(input int n);
    bitq_t q;
    for (int i = 0; i < n; i++) q.push_back(1'($urandom_range(0, 1)));
    return q;
  endfunction

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset    = 1'b1;
    ip_clk   = 1'b1;
    ip_latch = 1'b1;
    ip_out   = 1'b1;
    model_reset();
    m_stb = 0;
    wait_clks(5);
    compared += 3;
    if (lamps !== '0) begin
      mismatched++;
      $display("FAIL reset_lamps: got %h, want 0", lamps);
    end
    if (frame_stb !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_stb: got %b, want 0", frame_stb);
    end
    if (frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_err: got %b, want 0", frame_err);
    end
    reset = 1'b0;
    wait_clks(5);
  endtask

  task automatic test_good_frame();
    logic [FB-1:0] pat;
    pat = {(FB/8){8'hA5}};
    send_bits(word_bits(pat), 1'b1, -1);
    compared += 4;
    if (lamps !== pat) begin
      mismatched++;
      $display("FAIL good_lamps: got %h, want %h", lamps, pat);
    end
    if (frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL good_err: got %b, want 0", frame_err);
    end
    if (dut_stb !== 1) begin
      mismatched++;
      $display("FAIL good_stb: got %0d pulses, want 1", dut_stb);
    end
    if (m_stb !== dut_stb || lamps !== m_lamps) begin
      mismatched++;
      $display("FAIL good_model: stb %0d lamps %h, want stb %0d lamps %h", dut_stb, lamps, m_stb, m_lamps);
    end
  endtask

  task automatic test_short_frame();
    bitq_t nxt;
    send_bits(rand_bits(100), 1'b1, -1);
    nxt = word_bits(rand_word());
    send_bit(nxt[0], 1'b1, 1'b0);
    compared += 3;
    if (frame_err !== 1'b1 || m_err !== 1'b1) begin
      mismatched++;
      $display("FAIL short_err: got %b, want 1", frame_err);
    end
    if (lamps !== m_lamps) begin
      mismatched++;
      $display("FAIL short_lamps: got %h, want %h", lamps, m_lamps);
    end
    if (dut_stb !== m_stb) begin
      mismatched++;
      $display("FAIL short_stb: got %0d pulses, want %0d", dut_stb, m_stb);
    end
    nxt.pop_front();
    send_bits(nxt, 1'b0, -1);
    compared += 3;
    if (frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL short_recover_err: got %b, want 0", frame_err);
    end
    if (lamps !== m_lamps) begin
      mismatched++;
      $display("FAIL short_recover_lamps: got %h, want %h", lamps, m_lamps);
    end
    if (dut_stb !== m_stb) begin
      mismatched++;
      $display("FAIL short_recover_stb: got %0d pulses, want %0d", dut_stb, m_stb);
    end
  endtask

  task automatic test_long_frame();
    bitq_t b;
    logic [FB-1:0] w;
    w = rand_word();
    b = word_bits(w);
    send_bits(b, 1'b1, -1);
    compared += 3;
    if (lamps !== w) begin
      mismatched++;
      $display("FAIL long_lamps144: got %h, want %h", lamps, w);
    end
    if (frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL long_err144: got %b, want 0", frame_err);
    end
    if (dut_stb !== m_stb) begin
      mismatched++;
      $display("FAIL long_stb144: got %0d pulses, want %0d", dut_stb, m_stb);
    end
    send_bits(rand_bits(1), 1'b0, -1);
    compared++;
    if (frame_err !== 1'b1) begin
      mismatched++;
      $display("FAIL long_err145: got %b, want 1", frame_err);
    end
    send_bits(rand_bits(5), 1'b0, -1);
    compared += 2;
    if (lamps !== w || frame_err !== m_err) begin
      mismatched++;
      $display("FAIL long_hold: lamps %h err %b, want lamps %h err %b", lamps, frame_err, w, m_err);
    end
    if (dut_stb !== m_stb) begin
      mismatched++;
      $display("FAIL long_extra_stb: got %0d pulses, want %0d", dut_stb, m_stb);
    end
    w = rand_word();
    send_bits(word_bits(w), 1'b1, -1);
    compared++;
    if (lamps !== w || frame_err !== 1'b0 || dut_stb !== m_stb) begin
      mismatched++;
      $display("FAIL long_recover: lamps %h err %b stb %0d, want lamps %h err 0 stb %0d",
               lamps, frame_err, dut_stb, w, m_stb);
    end
  endtask

  task automatic test_reset_mid_frame();
    bitq_t b;
    logic [FB-1:0] w;
    b = word_bits(rand_word());
    for (int i = 0; i < 70; i++) send_bit(b[i], i == 0, 1'b0);
    @(negedge clk20);
    reset = 1'b1;
    model_reset();
    wait_clks(3);
    compared++;
    if (lamps !== '0 || frame_stb !== 1'b0 || frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_outputs: lamps %h stb %b err %b, want all 0", lamps, frame_stb, frame_err);
    end
    reset = 1'b0;
    for (int i = 70; i < FB; i++) send_bit(b[i], 1'b0, 1'b0);
    compared++;
    if (dut_stb !== m_stb || lamps !== '0) begin
      mismatched++;
      $display("FAIL midreset_tail: stb %0d lamps %h, want stb %0d lamps 0", dut_stb, lamps, m_stb);
    end
    w = rand_word();
    send_bits(word_bits(w), 1'b1, -1);
    compared++;
    if (lamps !== w || dut_stb !== m_stb || frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_recover: lamps %h stb %0d err %b, want lamps %h stb %0d err 0",
               lamps, dut_stb, frame_err, w, m_stb);
    end
  endtask

  // Repeated indicator word sent back to back, as the QSIC refreshes it.
  task automatic test_back_to_back();
    logic [FB-1:0] w;
    int stb_before;
    w = rand_word();
    for (int f = 0; f < 4; f++) begin
      stb_before = dut_stb;
      send_bits(word_bits(w), 1'b1, -1);
      compared++;
      if (lamps !== w || dut_stb !== stb_before + 1 || frame_err !== 1'b0) begin
        mismatched++;
        $display("FAIL b2b_frame%0d: lamps %h stb+%0d err %b, want lamps %h stb+1 err 0",
                 f, lamps, dut_stb - stb_before, frame_err, w);
      end
    end
    // Varied random words and a cross-check against the model.
    for (int f = 0; f < 2; f++) begin
      send_bits(word_bits(rand_word()), 1'b1, -1);
      compared++;
      if (lamps !== m_lamps || dut_stb !== m_stb || frame_err !== m_err) begin
        mismatched++;
        $display("FAIL b2b_rand%0d: lamps %h stb %0d err %b, want lamps %h stb %0d err %b",
                 f, lamps, dut_stb, frame_err, m_lamps, m_stb, m_err);
      end
    end
  endtask

`ifdef PANEL_RX_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic [FB-1:0] w;
    w = rand_word();
    send_bits(word_bits(w), 1'b1, 60);
    compared++;
    if (lamps !== w || dut_stb !== m_stb || frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL glitch_frame: lamps %h stb %0d err %b, want lamps %h stb %0d err 0",
               lamps, dut_stb, frame_err, w, m_stb);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_long_frame();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef PANEL_RX_GLITCH_FILTER_EN
    test_glitch();
`endif
    wait_clks(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_panel_rx
